// File: rtl/mod_mul_seq.sv
// rtl/mod_mul_seq.sv - iterative interleaved modular multiplier, c = (a * b) mod q, MSB first
module mod_mul_seq #(
  parameter int W  = 23,
  parameter int CW = 5
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] q_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] c_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CW-1:0] CNT_LOAD = CW'(W - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  c_q, c_d;
  logic          valid_q, valid_d;

  // One W+1-bit step: double, reduce once, optionally add a, reduce once.
  // Both sums stay below 2q, so a single conditional subtract is enough and
  // q = 2^W-1 still fits in W+1 bits.
  logic [W:0]   q_ext;
  logic [W:0]   dbl;
  logic [W:0]   dbl_red;
  logic [W:0]   sum;
  logic [W:0]   sum_red;
  logic [W-1:0] step;
  logic         b_bit;

  // Datapath for the current multiplier bit.
  always_comb begin
    q_ext   = {1'b0, q_q};
    dbl     = {acc_q, 1'b0};
    dbl_red = (dbl >= q_ext) ? (dbl - q_ext) : dbl;
    sum     = dbl_red + {1'b0, a_q};
    sum_red = (sum >= q_ext) ? (sum - q_ext) : sum;
    b_bit   = b_q[cnt_q];
    step    = b_bit ? W'(sum_red) : W'(dbl_red);
  end

  // Next-state logic for the IDLE -> BUSY -> DONE handshake sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    q_d     = q_q;
    c_d     = c_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          q_d     = q_i;
          acc_d   = '0;
          cnt_d   = CNT_LOAD;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        acc_d = step;
        if (cnt_q == '0) begin
          c_d     = step;
          valid_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        // c_o keeps its value after hand-off; only valid drops.
        if (ready_i) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous abort to IDLE.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      c_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      c_q     <= c_d;
      valid_q <= valid_d;
    end
  end

  assign ready_o = (state_q == ST_IDLE);
  assign valid_o = valid_q;
  assign c_o     = c_q;

endmodule

// File: tb/tb_mod_mul_seq.sv
// tb/tb_mod_mul_seq.sv - scoreboard bench for mod_mul_seq
module tb_mod_mul_seq;

  localparam int W  = 23;
  localparam int CW = 5;

  logic         clk_i = 1'b0;
  logic         rstn_i;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] a_i, b_i, q_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] c_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];

  mod_mul_seq #(.W(W), .CW(CW)) dut (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .a_i     (a_i),
    .b_i     (b_i),
    .q_i     (q_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .c_o     (c_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, b, q);
    longint unsigned p;
    p = (longint'(a) * longint'(b)) % longint'(q);
    return W'(p);
  endfunction

  // Issue one operation, then wait for and retire its result.
  task automatic do_op(input logic [W-1:0] a, b, q, input int bp, input bit pulse);
    int acc_cyc;
    bit seen;
    logic [W-1:0] exp;
    logic [W-1:0] c_hold;
    ready_i = 1'b0;
    chk("ready_idle", ready_o, 1);
    valid_i = 1'b1; a_i = a; b_i = b; q_i = q;
    @(posedge clk_i); #1;
    acc_cyc = cyc;
    exp_q.push_back(ref_mul(a, b, q));
    valid_i = 1'b0;
    a_i = W'($urandom); b_i = W'($urandom); q_i = W'($urandom);
    chk("ready_busy", ready_o, 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      valid_i = (pulse && i == 5);
      ready_i = 1'($urandom_range(0, 1));
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      if (valid_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk("timeout", {31'd0, seen}, 1);
    if (seen) begin
      chk("latency", cyc - acc_cyc, W);
      exp = exp_q.pop_front();
      chk("c_o", c_o, exp);
      c_hold = c_o;
      for (int k = 0; k < bp; k++) begin
        ready_i = 1'b0;
        valid_i = pulse;
        a_i = W'($urandom); b_i = W'($urandom);
        @(posedge clk_i); #1;
        chk("bp_valid", valid_o, 1);
        chk("bp_c", c_o, c_hold);
        chk("bp_ready", ready_o, 0);
      end
      valid_i = 1'b0;
      ready_i = 1'b1;
      @(posedge clk_i); #1;
      chk("handoff_valid", valid_o, 0);
      chk("handoff_ready", ready_o, 1);
      chk("handoff_c", c_o, c_hold);
      ready_i = 1'b0;
    end
  endtask

  initial begin
    logic [W-1:0] q, a, b;
    rstn_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    a_i = '0; b_i = '0; q_i = '0;
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_c", c_o, 0);
    chk("rst_ready", ready_o, 1);
    repeat (3) @(posedge clk_i);
    #3 rstn_i = 1'b1;
    @(posedge clk_i); #1;

    // Directed cases including boundary operands.
    do_op(23'd2, 23'd3, 23'd7, 0, 1'b0);
    chk("basic_val", c_o, 6);
    do_op(23'd5, 23'd4, 23'd7, 1, 1'b0);
    do_op(23'h7FE000, 23'h7FE000, 23'h7FE001, 0, 1'b0);
    chk("qm1_sq", c_o, 1);
    do_op(23'h123456, 23'd0, 23'h7FE001, 0, 1'b0);
    chk("b_zero", c_o, 0);
    do_op(23'd0, 23'h7FE000, 23'h7FE001, 0, 1'b0);
    chk("a_zero", c_o, 0);
    do_op(23'h7FFFFE, 23'h7FFFFE, 23'h7FFFFF, 0, 1'b0);
    chk("maxq_sq", c_o, 1);
    do_op(23'h400000, 23'd2, 23'h7FFFFF, 0, 1'b0);
    chk("maxq_wrap", c_o, 1);
    // Backpressure with operand pulses during BUSY and DONE.
    do_op(23'd1234567, 23'd7654321, 23'h7FE001, 5, 1'b1);
    chk("bp_result", c_o, ref_mul(23'd1234567, 23'd7654321, 23'h7FE001));
    repeat (3) begin
      @(posedge clk_i); #1;
      chk("idle_quiet", valid_o, 0);
    end

    // Reset during BUSY aborts immediately.
    valid_i = 1'b1; a_i = 23'd99; b_i = 23'd77; q_i = 23'h7FE001;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #3 rstn_i = 1'b0;
    #1;
    chk("midrst_valid", valid_o, 0);
    chk("midrst_c", c_o, 0);
    chk("midrst_ready", ready_o, 1);
    @(posedge clk_i);
    #3 rstn_i = 1'b1;
    @(posedge clk_i); #1;
    do_op(23'd1000, 23'd2000, 23'h7FE001, 0, 1'b0);
    chk("post_rst", c_o, 2000000);

    // Random operations with random backpressure.
    for (int n = 0; n < 2000; n++) begin
      q = W'($urandom_range(2, (1 << W) - 1));
      a = W'($urandom_range(0, int'(q) - 1));
      b = W'($urandom_range(0, int'(q) - 1));
      do_op(a, b, q, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    chk("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
